// File: rtl/seq_check_pkg.sv
// Shared definitions for the colour-sequence checker: sizes, colour and FSM
// encodings, and the round-length encoding where 4'd0 stands for 16.
package seq_check_pkg;

    localparam int COLOUR_W = 2;
    localparam int MAX_LEN  = 16;
    localparam int SEQ_W    = COLOUR_W * MAX_LEN;

    typedef enum logic [1:0] {
        COL_R = 2'd0,
        COL_G = 2'd1,
        COL_B = 2'd2,
        COL_Y = 2'd3
    } colour_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CHECK  = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    localparam logic [3:0] LEN16 = 4'd0;

    function automatic logic [4:0] len_decode(input logic [3:0] enc);
        return (enc == LEN16) ? 5'd16 : {1'b0, enc};
    endfunction

endpackage

// File: rtl/seq_check_if.sv
// Interface between the wait stage / game controller (master) and the
// sequence checker (slave).
interface seq_check_if;
    import seq_check_pkg::*;

    logic             en;
    logic             complete_wait;
    logic [SEQ_W-1:0] sequence_val;
    logic [SEQ_W-1:0] target_val;
    logic             busy;
    logic             done;
    logic             pass;
    logic             fail;
    logic [3:0]       mismatch_idx;
    logic [3:0]       round_len;
    logic             game_over;
    logic             win;
    logic [7:0]       best_score;

    modport master (
        output en, complete_wait, sequence_val, target_val,
        input  busy, done, pass, fail, mismatch_idx, round_len,
               game_over, win, best_score
    );

    modport slave (
        input  en, complete_wait, sequence_val, target_val,
        output busy, done, pass, fail, mismatch_idx, round_len,
               game_over, win, best_score
    );

endinterface

// File: rtl/seq_check_colour_sel.sv
// Picks entry idx (0 = oldest) out of a packed sequence of length len,
// where the newest entry sits in the lowest bits. len uses 4'd0 for 16.
module seq_colour_sel
    import seq_check_pkg::*;
(
    input  logic [SEQ_W-1:0] seq,
    input  logic [3:0]       len,
    input  logic [3:0]       idx,
    output colour_e          colour
);

    logic [COLOUR_W-1:0] entry [MAX_LEN];
    logic [3:0]          pos;

    generate
        for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_entry
            assign entry[gi] = seq[gi*COLOUR_W +: COLOUR_W];
        end
    endgenerate

    // Modulo-16 arithmetic makes len=0 (16) land on position 15 for idx 0.
    assign pos    = len - 4'd1 - idx;
    assign colour = colour_e'(entry[pos]);

endmodule

// File: rtl/seq_check.sv
// Serial player-vs-target sequence checker with round-length ownership.
// Optional best-score tracking is enabled by defining SEQ_CHECK_SCORE_EN.
module seq_check
    import seq_check_pkg::*;
#(
    parameter logic [3:0] START_LEN = 4'd1
) (
    input  logic        clk,
    input  logic        rst,
    seq_check_if.slave  bus
);

    state_e           state_q, state_d;
    logic             cw_prev_q, cw_prev_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic [SEQ_W-1:0] tgt_q, tgt_d;
    logic [4:0]       len_q, len_d;
    logic [3:0]       idx_q, idx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic             fail_q, fail_d;
    logic [3:0]       mis_idx_q, mis_idx_d;
    logic [3:0]       round_len_q, round_len_d;
    logic             game_over_q, game_over_d;
    logic             win_q, win_d;

    colour_e          ply_col;
    colour_e          tgt_col;
    logic             start;
    logic             match;
    logic             last;

    seq_colour_sel u_ply_sel (
        .seq    (seq_q),
        .len    (len_q[3:0]),
        .idx    (idx_q),
        .colour (ply_col)
    );

    seq_colour_sel u_tgt_sel (
        .seq    (tgt_q),
        .len    (len_q[3:0]),
        .idx    (idx_q),
        .colour (tgt_col)
    );

    assign start = bus.en && bus.complete_wait && !cw_prev_q && !game_over_q && !win_q;
    assign match = (ply_col == tgt_col);
    assign last  = ({1'b0, idx_q} == (len_q - 5'd1));

    always_comb begin
        state_d     = state_q;
        cw_prev_d   = bus.complete_wait;
        seq_d       = seq_q;
        tgt_d       = tgt_q;
        len_d       = len_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_d      = fail_q;
        mis_idx_d   = mis_idx_q;
        round_len_d = round_len_q;
        game_over_d = game_over_q;
        win_d       = win_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    seq_d   = bus.sequence_val;
                    tgt_d   = bus.target_val;
                    len_d   = len_decode(round_len_q);
                    idx_d   = 4'd0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (!match) begin
                    mis_idx_d   = idx_q;
                    fail_d      = 1'b1;
                    game_over_d = 1'b1;
                    state_d     = ST_RESULT;
                end else if (last) begin
                    pass_d    = 1'b1;
                    mis_idx_d = 4'd0;
                    // Passing the 16-entry round is the win; length stays at 16.
                    if (round_len_q == LEN16) begin
                        win_d = 1'b1;
                    end else begin
                        round_len_d = round_len_q + 4'd1;
                    end
                    state_d = ST_RESULT;
                end else begin
                    idx_d = idx_q + 4'd1;
                end
            end
            ST_RESULT: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cw_prev_q   <= 1'b0;
            seq_q       <= '0;
            tgt_q       <= '0;
            len_q       <= 5'd0;
            idx_q       <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_q      <= 1'b0;
            mis_idx_q   <= 4'd0;
            round_len_q <= START_LEN;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cw_prev_q   <= cw_prev_d;
            seq_q       <= seq_d;
            tgt_q       <= tgt_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            mis_idx_q   <= mis_idx_d;
            round_len_q <= round_len_d;
            game_over_q <= game_over_d;
            win_q       <= win_d;
        end
    end

`ifdef SEQ_CHECK_SCORE_EN
    logic [7:0] score_q, score_d;
    logic [7:0] best_q, best_d;
    logic       pass_hit;

    assign pass_hit = (state_q == ST_CHECK) && match && last;

    always_comb begin
        score_d = score_q;
        best_d  = best_q;
        if (pass_hit && (score_q != 8'hFF)) begin
            score_d = score_q + 8'd1;
        end
        if ((state_q == ST_RESULT) && (score_q > best_q)) begin
            best_d = score_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            score_q <= 8'd0;
            best_q  <= 8'd0;
        end else begin
            score_q <= score_d;
            best_q  <= best_d;
        end
    end

    assign bus.best_score = best_q;
`else
    assign bus.best_score = 8'd0;
`endif

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.fail         = fail_q;
    assign bus.mismatch_idx = mis_idx_q;
    assign bus.round_len    = round_len_q;
    assign bus.game_over    = game_over_q;
    assign bus.win          = win_q;

endmodule

// File: tb/tb_seq_check.sv
// Scoreboard bench for seq_check: each accepted start pushes its expected
// result and done-cycle; a monitor pops and compares on every done pulse.
module tb_seq_check;
    import seq_check_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_check_if bus ();

    seq_check dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic       pass;
        logic       fail;
        logic [3:0] idx;
        int         due;
        logic [3:0] rlen;
        logic       go;
        logic       win;
        logic [7:0] best;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state of the game
    logic [3:0] m_len;
    logic       m_go;
    logic       m_win;
    logic [7:0] m_score;
    logic [7:0] m_best;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [7:0] exp_best();
`ifdef SEQ_CHECK_SCORE_EN
        return m_best;
`else
        return 8'd0;
`endif
    endfunction

    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_done", bus.done, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                check_eq("latency",      cyc,              mon_e.due);
                check_eq("pass",         bus.pass,         mon_e.pass);
                check_eq("fail",         bus.fail,         mon_e.fail);
                check_eq("mismatch_idx", bus.mismatch_idx, mon_e.idx);
                check_eq("round_len",    bus.round_len,    mon_e.rlen);
                check_eq("game_over",    bus.game_over,    mon_e.go);
                check_eq("win",          bus.win,          mon_e.win);
                check_eq("best_score",   bus.best_score,   mon_e.best);
                check_eq("busy_at_done", bus.busy,         1'b0);
                $display("round done: len_after=%0d pass=%0b fail=%0b idx=%0d cycle=%0d",
                         bus.round_len, bus.pass, bus.fail, bus.mismatch_idx, cyc);
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.complete_wait = 1'b0;
        bus.en = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        check_eq("rst_busy",      bus.busy,         1'b0);
        check_eq("rst_done",      bus.done,         1'b0);
        check_eq("rst_pass",      bus.pass,         1'b0);
        check_eq("rst_fail",      bus.fail,         1'b0);
        check_eq("rst_idx",       bus.mismatch_idx, 4'd0);
        check_eq("rst_round_len", bus.round_len,    4'd1);
        check_eq("rst_game_over", bus.game_over,    1'b0);
        check_eq("rst_win",       bus.win,          1'b0);
        check_eq("rst_best",      bus.best_score,   8'd0);
        rst = 1'b0;
        m_len = 4'd1; m_go = 1'b0; m_win = 1'b0; m_score = 8'd0; m_best = 8'd0;
    endtask

    // Drives one accepted round and waits (bounded) for its result.
    task automatic start_round(input logic [31:0] player, input logic [31:0] target, input bit hold);
        exp_t e;
        int   len, k, i;
        logic found;
        logic [1:0] pc, tc;
        len = (m_len == 4'd0) ? 16 : int'(m_len);
        found = 1'b0;
        k = len;
        e.idx = 4'd0;
        for (i = 0; i < len; i++) begin
            pc = 2'((player >> (2 * (len - 1 - i))) & 32'h3);
            tc = 2'((target >> (2 * (len - 1 - i))) & 32'h3);
            if (!found && pc != tc) begin
                found = 1'b1;
                e.idx = 4'(i);
                k = i + 1;
            end
        end
        e.pass = !found;
        e.fail = found;
        if (found) begin
            m_go = 1'b1;
        end else begin
            if (m_score != 8'hFF) m_score = m_score + 8'd1;
            if (m_len == 4'd0) m_win = 1'b1;
            else m_len = m_len + 4'd1;
        end
        if (m_score > m_best) m_best = m_score;
        e.rlen = m_len;
        e.go   = m_go;
        e.win  = m_win;
        e.best = exp_best();
        $display("start: len=%0d player=%08h target=%08h expect_pass=%0b k=%0d", len, player, target, e.pass, k);

        @(negedge clk);
        bus.complete_wait = 1'b0;
        bus.en = 1'b1;
        bus.sequence_val = player;
        bus.target_val = target;
        @(negedge clk);
        bus.complete_wait = 1'b1;
        @(negedge clk);
        e.due = cyc + k + 1;
        sb.push_back(e);
        check_eq("busy_start", bus.busy, 1'b1);
        // Inputs change mid-check; the captured copies must be used.
        bus.sequence_val = ~player;
        bus.target_val = 32'h0;
        for (int w = 0; w < 40 && sb.size() != 0; w++) @(negedge clk);
        check_eq("drain", sb.size(), 0);
        sb.delete();
        if (hold) begin
            repeat (15) @(negedge clk);
            check_eq("no_retrigger_busy", bus.busy, 1'b0);
        end
        bus.complete_wait = 1'b0;
    endtask

    task automatic try_ignored(input string tag);
        @(negedge clk);
        bus.en = 1'b1;
        bus.complete_wait = 1'b0;
        @(negedge clk);
        bus.complete_wait = 1'b1;
        repeat (20) @(negedge clk);
        check_eq(tag, bus.busy, 1'b0);
        bus.complete_wait = 1'b0;
    endtask

    function automatic logic [31:0] flip_entry(input logic [31:0] t, input int len, input int j);
        return t ^ (32'h1 << (2 * (len - 1 - j)));
    endfunction

    logic [31:0] t;

    initial begin
        bus.en = 1'b0;
        bus.complete_wait = 1'b0;
        bus.sequence_val = '0;
        bus.target_val = '0;

        // Single-entry pass, then lengths 2 and 3, then a late mismatch at len 4
        do_reset();
        start_round(32'h2, 32'h2, 1'b1);
        for (int r = 0; r < 2; r++) begin
            t = $urandom;
            start_round(t, t, 1'b0);
        end
        start_round(32'h1A, 32'h1B, 1'b0);
        try_ignored("ignored_after_fail");

        // Early exit on the oldest entry
        do_reset();
        for (int r = 0; r < 3; r++) begin
            t = $urandom;
            start_round(t, t, 1'b0);
        end
        t = $urandom;
        start_round(flip_entry(t, 4, 0), t, 1'b0);
        try_ignored("ignored_after_fail2");

        // Climb to 16 entries and win
        do_reset();
        for (int r = 0; r < 15; r++) begin
            t = $urandom;
            start_round(t, t, 1'b0);
        end
        check_eq("len16_encoding", bus.round_len, 4'd0);
        start_round(32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        try_ignored("ignored_after_win");

        // Edge while disabled is dropped, and stays dropped once enabled
        do_reset();
        @(negedge clk);
        bus.en = 1'b0;
        bus.complete_wait = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("en0_busy", bus.busy, 1'b0);
        bus.en = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("en0_late_busy", bus.busy, 1'b0);
        bus.complete_wait = 1'b0;

        // Reset in the middle of a 3-entry check
        t = $urandom;
        start_round(t, t, 1'b0);
        t = $urandom;
        start_round(t, t, 1'b0);
        @(negedge clk);
        bus.sequence_val = 32'h5;
        bus.target_val = 32'h5;
        @(negedge clk);
        bus.complete_wait = 1'b1;
        @(negedge clk);
        check_eq("abort_busy_start", bus.busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        bus.complete_wait = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_len = 4'd1; m_go = 1'b0; m_win = 1'b0; m_score = 8'd0; m_best = 8'd0;
        repeat (6) @(negedge clk);
        check_eq("abort_busy",      bus.busy,       1'b0);
        check_eq("abort_round_len", bus.round_len,  4'd1);
        check_eq("abort_pass",      bus.pass,       1'b0);
        check_eq("abort_best",      bus.best_score, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
